// File: rtl/vending_pkg.sv
// Shared constants for the vending machine front end.
//   - Button IDs as seen by the FSM on req_id.
//   - Default button count, lockout length and counter width.
//   - id_width(): width of a button ID for a given button count (min 1).
package vending_pkg;

  localparam int BTN_NICKEL  = 0;
  localparam int BTN_DIME    = 1;
  localparam int BTN_QUARTER = 2;
  localparam int BTN_RETURN  = 3;

  localparam int NUM_BTN_DEF     = 4;
  localparam int LOCKOUT_CYC_DEF = 8;
  localparam int CW_DEF          = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDW_DEF = id_width(NUM_BTN_DEF);

endpackage

// File: rtl/btn_lockout_ctr.sv
// Per-button retrigger lockout counter.
//   gclk, grst_n : clock, async active-low reset (counter clears to 0)
//   load         : accepted pulse this cycle, reload with LOAD_VAL
//   locked       : counter nonzero, further pulses must be ignored
// Counts down by one per cycle and parks at zero.
module btn_lockout_ctr #(
  parameter int CW       = 4,
  parameter int LOAD_VAL = 8
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic load,
  output logic locked
);

  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)          cnt <= '0;
    else if (load)        cnt <= CW'(LOAD_VAL);
    else if (cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign locked = (cnt != '0);

endmodule

// File: rtl/coin_button_scheduler.sv
// Button event scheduler between the button synchronizers and the vending FSM.
//   Clk, Rst     : clock, async active-low reset
//   btn_pulse    : one-cycle synchronized pulses, one bit per button
//   req_valid/id : registered event presented to the FSM
//   req_ready    : FSM takes the presented event this cycle
//   pending      : buttons waiting to be served
//   ovr          : sticky, a pulse arrived while that button was still pending
//   ovr_clr      : clear all ovr bits (a same-cycle new overrun still sets)
// Pending buttons are served one at a time, round-robin from the button after
// the last one granted.
module coin_button_scheduler
  import vending_pkg::*;
#(
  parameter int NUM_BTN     = NUM_BTN_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter int CW          = CW_DEF,
  parameter int IDW         = id_width(NUM_BTN)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               req_valid,
  output logic [IDW-1:0]     req_id,
  input  logic               req_ready,
  output logic [NUM_BTN-1:0] pending,
  output logic [NUM_BTN-1:0] ovr,
  input  logic               ovr_clr
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } req_t;

  req_t               req_q, req_n;
  logic [NUM_BTN-1:0] pend_q, pend_n;
  logic [NUM_BTN-1:0] ovr_q, ovr_n;
  logic [IDW-1:0]     ptr_q, ptr_n;

  logic [NUM_BTN-1:0] locked, accept, clr, ovr_set;
  logic               xfer;
  logic [IDW-1:0]     nxt_id, start;
  logic               found;
  logic [IDW-1:0]     pick_id;

  // Explicit wrap so a non-power-of-2 button count never yields an
  // out-of-range ID.
  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    return (v == IDW'(NUM_BTN-1)) ? '0 : v + IDW'(1);
  endfunction

  // Circular search of cand starting at start; returns {found, id}.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_BTN-1:0] cand,
                                           input logic [IDW-1:0]     start_id);
    logic [IDW-1:0] idx;
    logic           f;
    logic [IDW-1:0] id;
    idx = start_id;
    f   = 1'b0;
    id  = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (!f && cand[idx]) begin
        f  = 1'b1;
        id = idx;
      end
      idx = inc_wrap(idx);
    end
    return {f, id};
  endfunction

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lock
    btn_lockout_ctr #(.CW(CW), .LOAD_VAL(LOCKOUT_CYC)) u_lock (
      .gclk   (Clk),
      .grst_n (Rst),
      .load   (accept[i]),
      .locked (locked[i])
    );
  end

  assign accept = btn_pulse & ~locked;
  assign xfer   = req_q.vld & req_ready;
  assign nxt_id = inc_wrap(req_q.id);
  // After a grant the next search starts just past the granted button.
  assign start  = xfer ? nxt_id : ptr_q;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_BTN; i++)
      clr[i] = xfer && (req_q.id == IDW'(i));
  end

  always_comb begin
    req_n = req_q;
    ptr_n = ptr_q;
    {found, pick_id} = rr_pick(pend_q & ~clr, start);
    // Handshake clear happens before the set, so a pulse landing on the
    // cycle its own event is taken re-arms pending without an overrun.
    ovr_set = accept & pend_q & ~clr;
    pend_n  = (pend_q & ~clr) | accept;
    ovr_n   = (ovr_clr ? '0 : ovr_q) | ovr_set;
    if (xfer) ptr_n = nxt_id;
    if (!req_q.vld || xfer) begin
      req_n.vld = found;
      if (found) req_n.id = pick_id;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      req_q  <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      ptr_q  <= '0;
    end else begin
      req_q  <= req_n;
      pend_q <= pend_n;
      ovr_q  <= ovr_n;
      ptr_q  <= ptr_n;
    end
  end

  assign req_valid = req_q.vld;
  assign req_id    = req_q.id;
  assign pending   = pend_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_coin_button_scheduler.sv
module tb_coin_button_scheduler;
  import vending_pkg::*;

  logic       Clk_tb = 1'b0;
  logic       rst_n;
  logic [3:0] btn_pulse;
  logic       req_valid;
  logic [1:0] req_id;
  logic       req_ready;
  logic [3:0] pending;
  logic [3:0] ovr;
  logic       ovr_clr;

  int checks = 0;
  int errors = 0;
  int xfer_cnt [4];

  coin_button_scheduler dut (
    .Clk       (Clk_tb),
    .Rst       (rst_n),
    .btn_pulse (btn_pulse),
    .req_valid (req_valid),
    .req_id    (req_id),
    .req_ready (req_ready),
    .pending   (pending),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  always #5 Clk_tb = ~Clk_tb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk_tb);
      #1;
    end
  endtask

  // Transfer counter plus hold-stability check under backpressure.
  logic       p_vld, p_rdy, p_rst;
  logic [1:0] p_id;
  initial begin
    p_vld = 1'b0; p_rdy = 1'b0; p_rst = 1'b0; p_id = '0;
    for (int i = 0; i < 4; i++) xfer_cnt[i] = 0;
  end
  always @(negedge Clk_tb) begin
    if (rst_n && p_rst && p_vld && !p_rdy) begin
      chk("hold_vld", {31'd0, req_valid}, 32'd1);
      chk("hold_id", {30'd0, req_id}, {30'd0, p_id});
    end
    if (rst_n && req_valid && req_ready) xfer_cnt[req_id] = xfer_cnt[req_id] + 1;
    p_vld = req_valid; p_rdy = req_ready; p_id = req_id; p_rst = rst_n;
  end

  int n0;

  initial begin
    rst_n = 1'b0; btn_pulse = '0; req_ready = 1'b0; ovr_clr = 1'b0;
    #3;
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_id", {30'd0, req_id}, 32'd0);
    chk("rst_ovr", {28'd0, ovr}, 32'd0);
    @(negedge Clk_tb); rst_n = 1'b1;
    tick();

    // Round-robin from pointer 0.
    req_ready = 1'b1; btn_pulse = 4'b1111; tick(); btn_pulse = '0;
    chk("rr_pend", {28'd0, pending}, 32'hF);
    chk("rr_v0", {31'd0, req_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_vld", {31'd0, req_valid}, 32'd1);
      chk("rr_id", {30'd0, req_id}, k);
    end
    tick();
    chk("rr_done", {31'd0, req_valid}, 32'd0);
    tick(10);
    btn_pulse = 4'b1001; tick(); btn_pulse = '0;
    tick(); chk("rr2_a", {29'd0, req_valid, req_id}, {29'd0, 1'b1, 2'd0});
    tick(); chk("rr2_b", {29'd0, req_valid, req_id}, {29'd0, 1'b1, 2'd3});
    tick(); chk("rr2_end", {31'd0, req_valid}, 32'd0);
    tick(10);

    // Single pulse.
    btn_pulse = 4'b0010; tick(); btn_pulse = '0;
    chk("sp_pend", {28'd0, pending}, 32'h2);
    chk("sp_v0", {31'd0, req_valid}, 32'd0);
    tick(); chk("sp_req", {29'd0, req_valid, req_id}, {29'd0, 1'b1, 2'd1});
    tick();
    chk("sp_vdone", {31'd0, req_valid}, 32'd0);
    chk("sp_pdone", {28'd0, pending}, 32'd0);
    chk("sp_ovr", {28'd0, ovr}, 32'd0);
    tick(10);

    // Backpressure.
    req_ready = 1'b0;
    btn_pulse = 4'b0100; tick(); btn_pulse = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_req", {29'd0, req_valid, req_id}, {29'd0, 1'b1, 2'd2});
      tick();
    end
    n0 = xfer_cnt[2];
    req_ready = 1'b1; tick();
    chk("bp_vdone", {31'd0, req_valid}, 32'd0);
    chk("bp_cnt", xfer_cnt[2], n0 + 1);
    tick(10);

    // Lockout: accepted at cycle 0, ignored at 3 and 7, accepted at 9.
    n0 = xfer_cnt[BTN_NICKEL];
    btn_pulse = 4'b0001; tick();
    for (int c = 1; c <= 9; c++) begin
      btn_pulse = (c == 3 || c == 7 || c == 9) ? 4'b0001 : 4'b0000;
      tick();
      if (c == 8) chk("lk_one", xfer_cnt[BTN_NICKEL], n0 + 1);
    end
    btn_pulse = '0;
    tick(3);
    chk("lk_two", xfer_cnt[BTN_NICKEL], n0 + 2);
    chk("lk_ovr", {28'd0, ovr}, 32'd0);
    tick(10);

    // Overrun: second accepted pulse while still pending.
    req_ready = 1'b0;
    n0 = xfer_cnt[BTN_RETURN];
    btn_pulse = 4'b1000; tick(); btn_pulse = '0;
    tick(9);
    chk("ov_noovr", {28'd0, ovr}, 32'd0);
    btn_pulse = 4'b1000; tick(); btn_pulse = '0;
    chk("ov_set", {28'd0, ovr}, 32'h8);
    chk("ov_req", {29'd0, req_valid, req_id}, {29'd0, 1'b1, 2'd3});
    ovr_clr = 1'b1; req_ready = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ov_clr", {28'd0, ovr}, 32'd0);
    tick(3);
    chk("ov_cnt", xfer_cnt[BTN_RETURN], n0 + 1);
    chk("ov_idle", {31'd0, req_valid}, 32'd0);
    tick(10);

    // Pulse on the cycle its own event is taken: clear, then set.
    req_ready = 1'b0;
    btn_pulse = 4'b0100; tick(); btn_pulse = '0;
    tick(10);
    req_ready = 1'b1; btn_pulse = 4'b0100; tick(); btn_pulse = '0;
    chk("cs_pend", {28'd0, pending}, 32'h4);
    chk("cs_ovr", {28'd0, ovr}, 32'd0);
    chk("cs_v0", {31'd0, req_valid}, 32'd0);
    tick(); chk("cs_req", {29'd0, req_valid, req_id}, {29'd0, 1'b1, 2'd2});
    tick(); chk("cs_done", {31'd0, req_valid}, 32'd0);
    tick(10);

    // Asynchronous reset mid-handshake.
    req_ready = 1'b0;
    btn_pulse = 4'b0110; tick(); btn_pulse = '0;
    tick();
    chk("mr_pend", {28'd0, pending}, 32'h6);
    chk("mr_vld", {31'd0, req_valid}, 32'd1);
    n0 = xfer_cnt[1] + xfer_cnt[2];
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rpend", {28'd0, pending}, 32'd0);
    chk("mr_rvld", {31'd0, req_valid}, 32'd0);
    chk("mr_rid", {30'd0, req_id}, 32'd0);
    chk("mr_rovr", {28'd0, ovr}, 32'd0);
    @(negedge Clk_tb); rst_n = 1'b1; req_ready = 1'b1;
    tick(4);
    chk("mr_stale_v", {31'd0, req_valid}, 32'd0);
    chk("mr_stale_p", {28'd0, pending}, 32'd0);
    chk("mr_cnt", xfer_cnt[1] + xfer_cnt[2], n0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
